// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry/timing for the SRAM macro access sequencer.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned T_PRE_DEF   = 2;
  localparam int unsigned T_WL_DEF    = 3;
  localparam int unsigned T_SENSE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_GAP   = 3'd2,
    ST_ACT   = 3'd3,
    ST_SENSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter; expired_o is registered and high during the last cycle of a loaded interval.
module sram_ctrl_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != W'(0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= W'(0);
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/sram_macro_ctrl.sv
// Single-word access sequencer for the analog SRAM array: precharge, gap, word-line,
// write-drive / sense, with every array-facing control registered.
module sram_macro_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned T_PRE   = T_PRE_DEF,
  parameter int unsigned T_WL    = T_WL_DEF,
  parameter int unsigned T_SENSE = T_SENSE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              pre_n,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              we_drv,
  output logic [DATA_W-1:0] din,
  output logic              sae,
  input  logic [DATA_W-1:0] dout
);

  localparam int unsigned TMR_W = $clog2(max3(T_PRE, T_WL, T_SENSE) + 1);

  state_t              state_q, state_d;
  logic                xfer;
  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_exp;

  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                pre_n_q, wl_en_q, we_drv_q, sae_q, rsp_valid_q;
  logic [ADDR_W-1:0]   wl_addr_q;
  logic [DATA_W-1:0]   din_q, rsp_rdata_q;

  assign cmd_ready = rst_n & ena & (state_q == ST_IDLE);
  assign xfer      = cmd_valid & cmd_ready;

  sram_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  // Next-state and timer-load decode.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(0);
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d  = ST_PRE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_PRE);
        end
      end
      ST_PRE: begin
        if (tmr_exp) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d  = ST_ACT;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_WL);
      end
      ST_ACT: begin
        if (tmr_exp) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_SENSE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_SENSE);
          end
        end
      end
      ST_SENSE: begin
        if (tmr_exp) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Array controls are decoded from the upcoming state so they line up with it cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= ADDR_W'(0);
      wdata_q     <= DATA_W'(0);
      pre_n_q     <= 1'b0;
      wl_en_q     <= 1'b0;
      we_drv_q    <= 1'b0;
      sae_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      wl_addr_q   <= ADDR_W'(0);
      din_q       <= DATA_W'(0);
      rsp_rdata_q <= DATA_W'(0);
    end else begin
      state_q <= state_d;
      if (xfer) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      pre_n_q     <= (state_d == ST_GAP) || (state_d == ST_ACT) || (state_d == ST_SENSE);
      wl_en_q     <= (state_d == ST_ACT) || (state_d == ST_SENSE);
      we_drv_q    <= (state_d == ST_ACT) && we_q;
      sae_q       <= (state_d == ST_SENSE);
      rsp_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_ACT) begin
        wl_addr_q <= addr_q;
        if (we_q) din_q <= wdata_q;
      end
      if ((state_q == ST_SENSE) && tmr_exp) rsp_rdata_q <= dout;
    end
  end

  assign pre_n     = pre_n_q;
  assign wl_en     = wl_en_q;
  assign wl_addr   = wl_addr_q;
  assign we_drv    = we_drv_q;
  assign din       = din_q;
  assign sae       = sae_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_macro_ctrl.sv
// Bench for sram_macro_ctrl: default-timing instance plus a T=1 instance, each driving a
// behavioural array, checked against a per-cycle timeline derived from the timing parameters.
module tb_sram_macro_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic       cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       rsp_valid [2];
  logic       pre_n     [2];
  logic       wl_en     [2];
  logic       we_drv    [2];
  logic       sae       [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] din       [2];
  logic [7:0] dout      [2];
  logic [3:0] wl_addr   [2];

  logic [7:0] amem0 [16];
  logic [7:0] amem1 [16];

  logic [7:0] ref_mem    [2][16];
  logic [7:0] last_rdata [2];
  logic [7:0] last_din   [2];
  logic [3:0] last_wla   [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_macro_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .pre_n(pre_n[0]), .wl_en(wl_en[0]), .wl_addr(wl_addr[0]),
    .we_drv(we_drv[0]), .din(din[0]), .sae(sae[0]), .dout(dout[0])
  );

  sram_macro_ctrl #(.T_PRE(1), .T_WL(1), .T_SENSE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .pre_n(pre_n[1]), .wl_en(wl_en[1]), .wl_addr(wl_addr[1]),
    .we_drv(we_drv[1]), .din(din[1]), .sae(sae[1]), .dout(dout[1])
  );

  // Behavioural bit-cell arrays: written while word line and write driver are both on.
  always @(posedge clk) if (wl_en[0] && we_drv[0]) amem0[wl_addr[0]] <= din[0];
  always @(posedge clk) if (wl_en[1] && we_drv[1]) amem1[wl_addr[1]] <= din[1];

  always_comb begin
    dout[0] = amem0[wl_addr[0]];
    dout[1] = amem1[wl_addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_pre_n", pre_n[s], 0);
    chk("rst_wl_en", wl_en[s], 0);
    chk("rst_we_drv", we_drv[s], 0);
    chk("rst_sae", sae[s], 0);
    chk("rst_wl_addr", wl_addr[s], 0);
    chk("rst_din", din[s], 0);
    chk("rst_rsp_valid", rsp_valid[s], 0);
    chk("rst_rsp_rdata", rsp_rdata[s], 0);
    chk("rst_cmd_ready", cmd_ready[s], 0);
  endtask

  task automatic issue(input int s, input logic we, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_we       = we;
    cmd_addr     = a;
    cmd_wdata    = d;
    cmd_valid[s] = 1'b1;
    #1;
    while (!cmd_ready[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", cmd_ready[s], 1);
    @(posedge clk);
    #1;
  endtask

  // One access, checked cycle by cycle through the cycle after its response.
  task automatic run_cmd(input int s, input logic we, input logic [3:0] a, input logic [7:0] d,
                         input logic keep, input logic drop);
    int tp, tw, ts, lat;
    logic act;
    logic [7:0] exp_rd;
    tp = (s == 1) ? 1 : 2;
    tw = (s == 1) ? 1 : 3;
    ts = (s == 1) ? 1 : 2;
    lat = we ? (tp + tw + 2) : (tp + tw + ts + 2);
    exp_rd = we ? last_rdata[s] : ref_mem[s][a];
    issue(s, we, a, d);
    cmd_valid[s] = keep;
    cmd_we       = 1'($urandom);
    cmd_addr     = 4'($urandom);
    cmd_wdata    = 8'($urandom);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      act = (k >= tp + 2) && (k <= tp + tw + 1);
      chk("pre_n", pre_n[s], (k >= tp + 1) && (k <= lat - 1));
      chk("wl_en", wl_en[s], (k >= tp + 2) && (k <= lat - 1));
      chk("we_drv", we_drv[s], we && act);
      chk("sae", sae[s], !we && (k >= tp + tw + 2) && (k <= lat - 1));
      chk("rsp_valid", rsp_valid[s], k == lat);
      chk("cmd_ready", cmd_ready[s], (k == lat + 1) && ena);
      chk("wl_addr", wl_addr[s], (k >= tp + 2) ? a : last_wla[s]);
      chk("din", din[s], (we && k >= tp + 2) ? d : last_din[s]);
      chk("rsp_rdata", rsp_rdata[s], (!we && k >= lat) ? exp_rd : last_rdata[s]);
      chk("inv_wl_pre", wl_en[s] & ~pre_n[s], 0);
      chk("inv_we_sae", we_drv[s] & sae[s], 0);
      if (drop && k == tp + 2) ena = 1'b0;
    end
    last_wla[s] = a;
    if (we) begin
      last_din[s]    = d;
      ref_mem[s][a]  = d;
    end else begin
      last_rdata[s] = exp_rd;
    end
    if (drop) begin
      ena = 1'b1;
      #1;
      chk("ready_after_ena", cmd_ready[s], 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    cmd_we = 1'b0;
    cmd_addr = 4'h0;
    cmd_wdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i]  = 1'b0;
      last_rdata[i] = 8'h00;
      last_din[i]   = 8'h00;
      last_wla[i]   = 4'h0;
    end

    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_por0", cmd_ready[0], 1);
    chk("ready_after_por1", cmd_ready[1], 1);

    // Directed write then read-back at 0x5.
    run_cmd(0, 1'b1, 4'h5, 8'hA5, 1'b0, 1'b0);
    run_cmd(0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0);

    // ena low while idle blocks acceptance.
    ena = 1'b0;
    cmd_valid[0] = 1'b1;
    cmd_we = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ena_blk_ready", cmd_ready[0], 0);
      chk("ena_blk_pre_n", pre_n[0], 0);
      chk("ena_blk_wl_en", wl_en[0], 0);
      chk("ena_blk_rsp", rsp_valid[0], 0);
    end
    cmd_valid[0] = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    // ena dropped during ACT: access still completes.
    run_cmd(0, 1'b1, 4'h9, 8'($urandom), 1'b0, 1'b1);
    run_cmd(0, 1'b0, 4'h9, 8'h00, 1'b0, 1'b1);

    // Continuous valid, alternating write/read over every address.
    for (int a = 0; a < 16; a++) begin
      run_cmd(0, 1'b1, 4'(a), 8'($urandom), 1'b1, 1'b0);
      run_cmd(0, 1'b0, 4'(a), 8'h00, 1'b1, 1'b0);
    end
    cmd_valid[0] = 1'b0;
    @(negedge clk);

    // Reset held two cycles in the middle of a read aborts it without a response.
    issue(0, 1'b0, 4'h5, 8'h00);
    cmd_valid[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("pre_abort_rsp", rsp_valid[0], 0);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_ready_low", cmd_ready[0], 0);
    repeat (2) begin
      @(negedge clk);
      chk_reset(0);
      chk_reset(1);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", cmd_ready[0], 1);
    @(negedge clk);
    chk("rst_rel_ready_cyc", cmd_ready[0], 1);
    chk("rst_rel_no_rsp", rsp_valid[0], 0);
    for (int i = 0; i < 2; i++) begin
      last_rdata[i] = 8'h00;
      last_din[i]   = 8'h00;
      last_wla[i]   = 4'h0;
    end
    run_cmd(0, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0);

    // Minimum timing instance: fill, then random mixed traffic.
    for (int a = 0; a < 16; a++) run_cmd(1, 1'b1, 4'(a), 8'($urandom), 1'b0, 1'b0);
    repeat (24) run_cmd(1, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    cmd_valid[1] = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
